// File: rtl/rs_issue_arbiter.sv
// rs_issue_arbiter
//
// Reservation-station issue scheduler. It picks one ready RS entry and holds
// it in a registered grant until the functional unit accepts it. On accept it
// returns a one-hot clear mask so the RS can free that entry. On the same edge
// it loads the next pick, so a stream of accepts issues one entry per cycle.
//
// Optional feature macro: RS_ISSUE_RR_EN
//   defined   : rotating priority, scanning upward from rr_ptr with wrap.
//   undefined : fixed priority, lowest ready index wins (no rr_ptr).
//
// Parameters:
//   N            number of RS entries (>= 2, default `RS_SIZE = 32)
//
// Ports:
//   clock        system clock, all state on posedge
//   reset        synchronous, active-high
//   ready_vec    [N]  per-entry "operands ready, not yet issued"
//   squash       flush; drops any held grant, blocks load and clear
//   fu_ready     FU accepts the presented grant this cycle
//   issue_valid  a grant is presented (state HOLD)
//   issue_oh     [N]  one-hot granted entry, zero when idle
//   issue_idx    [$clog2(N)] binary index of the grant, zero when idle
//   clear_oh     [N]  combinational: issue_oh on accept, else zero

`ifndef RS_SIZE
`define RS_SIZE 32
`endif

module rs_issue_arbiter #(
    parameter int N = `RS_SIZE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         ready_vec,
    input  logic                 squash,
    input  logic                 fu_ready,
    output logic                 issue_valid,
    output logic [N-1:0]         issue_oh,
    output logic [$clog2(N)-1:0] issue_idx,
    output logic [N-1:0]         clear_oh
);

    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [N-1:0]  grant_oh, grant_oh_next;
    logic [IW-1:0] grant_idx, grant_idx_next;

    logic          accept;
    logic          load;
    logic [N-1:0]  cand;
    logic          pick_found;
    logic [IW-1:0] pick_idx;

    // Lowest set bit of v. MSB of the result is the "found" flag.
    function automatic logic [IW:0] find_first(input logic [N-1:0] v);
        logic [IW:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = {1'b1, IW'(i)};
        end
        return r;
    endfunction

    function automatic logic [N-1:0] to_onehot(input logic [IW-1:0] idx);
        logic [N-1:0] one;
        one = '0;
        one[0] = 1'b1;
        return one << idx;
    endfunction

    assign accept   = (state == HOLD) & fu_ready & ~squash;
    assign clear_oh = accept ? grant_oh : '0;
    assign load     = ~squash & ((state == IDLE) | accept);

    // The entry being accepted is still set in ready_vec this cycle; the RS
    // only drops it next cycle, so it must not be picked again.
    assign cand = ready_vec & ~clear_oh;

`ifdef RS_ISSUE_RR_EN
    localparam logic [IW:0] N_W = (IW + 1)'(N);

    logic [IW-1:0] rr_ptr, rr_ptr_next;
    logic [N-1:0]  cand_rot;
    logic [IW:0]   rot_pick;

    // (base + off) mod N; works for non-power-of-two N.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base,
                                               input logic [IW-1:0] off);
        logic [IW:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= N_W) s = s - N_W;
        return s[IW-1:0];
    endfunction

    // Rotate cand down by sh so that entry rr_ptr lands at bit 0; the
    // doubled vector makes the wrap correct for any N.
    function automatic logic [N-1:0] rotate_down(input logic [N-1:0] v,
                                                 input logic [IW-1:0] sh);
        return N'({v, v} >> sh);
    endfunction

    assign cand_rot   = rotate_down(cand, rr_ptr);
    assign rot_pick   = find_first(cand_rot);
    assign pick_found = rot_pick[IW];
    assign pick_idx   = wrap_add(rr_ptr, rot_pick[IW-1:0]);

    assign rr_ptr_next = accept ? wrap_add(grant_idx, IW'(1)) : rr_ptr;

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end
`else
    logic [IW:0] fix_pick;

    assign fix_pick   = find_first(cand);
    assign pick_found = fix_pick[IW];
    assign pick_idx   = fix_pick[IW-1:0];
`endif

    // Next-state / next-grant. Squash wins over load; without a load the
    // grant registers are frozen.
    always_comb begin
        state_next     = state;
        grant_oh_next  = grant_oh;
        grant_idx_next = grant_idx;
        if (squash) begin
            state_next     = IDLE;
            grant_oh_next  = '0;
            grant_idx_next = '0;
        end else if (load) begin
            if (pick_found) begin
                state_next     = HOLD;
                grant_oh_next  = to_onehot(pick_idx);
                grant_idx_next = pick_idx;
            end else begin
                state_next     = IDLE;
                grant_oh_next  = '0;
                grant_idx_next = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            grant_oh  <= '0;
            grant_idx <= '0;
        end else begin
            state     <= state_next;
            grant_oh  <= grant_oh_next;
            grant_idx <= grant_idx_next;
        end
    end

    assign issue_valid = (state == HOLD);
    assign issue_oh    = grant_oh;
    assign issue_idx   = grant_idx;

endmodule
